dma_mem_responder: RTL and testbench
====================================

DMA_MEM_RESPONDER -- requirements
Module: dma_mem_responder

Interface
REQ-001 Parameter: MEM_LAT, default 2, memory read latency in clk cycles (1..7).
REQ-002 Parameter: MAX_HOLD, default 256, maximum consecutive granted cycles before forced CPU slot.
REQ-003 Port: clk  in  1  system clock; all logic on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: clear  in  1  synchronous IOCLR; returns block to idle.
REQ-006 Port: dmaREQ  in  1  DMA request from disk controller.
REQ-007 Port: dmaRD  in  1  one-cycle read strobe, valid only while dmaGNT.
REQ-008 Port: dmaWR  in  1  one-cycle write strobe, valid only while dmaGNT.
REQ-009 Port: dmaADDR  in  15  DMA word address.
REQ-010 Port: dmaDOUT  in  12  write data from disk.
REQ-011 Port: dmaGNT  out  1  DMA grant.
REQ-012 Port: dmaDIN  out  12  read data to disk.
REQ-013 Port: dmaACK  out  1  one-cycle pulse: read data valid or write committed.
REQ-014 Port: cpuBUSY  in  1  CPU mid memory cycle; grant forbidden while high.
REQ-015 Port: cpuHOLD  out  1  stalls CPU at next cycle boundary.
REQ-016 Port: memADDR  out  15  memory address.
REQ-017 Port: memDOUT  out  12  memory write data.
REQ-018 Port: memDIN  in  12  memory read data.
REQ-019 Port: memWE / memRE  out  1 each  one-cycle write / read enables.
REQ-020 Port: dmaERR  out  1  sticky protocol error.

Function
REQ-021 States SHALL be: IDLE, WAITCPU, GRANTED, RDWAIT, YIELD.
REQ-022 IDLE: dmaREQ=1 -> WAITCPU, cpuHOLD=1 from next cycle.
REQ-023 WAITCPU: cpuBUSY=0 -> GRANTED, dmaGNT=1 next cycle; dmaREQ=0 -> IDLE, cpuHOLD=0.
REQ-024 GRANTED, dmaWR=1: memWE=1, memADDR=dmaADDR, memDOUT=dmaDOUT next cycle; dmaACK same cycle as memWE.
REQ-025 GRANTED, dmaRD=1: memRE=1, memADDR=dmaADDR next cycle -> RDWAIT; dmaDIN registered from memDIN MEM_LAT cycles after memRE, dmaACK=1 with it, return to GRANTED.
REQ-026 Strobes arriving in RDWAIT SHALL be ignored and set dmaERR.
REQ-027 dmaRD and dmaWR high together: no memory access, dmaERR=1, stay GRANTED.
REQ-028 Strobes while dmaGNT=0: ignored, dmaERR=1.
REQ-029 GRANTED, dmaREQ=0 and no read pending: dmaGNT=0 and cpuHOLD=0 next cycle -> IDLE.
REQ-030 dmaREQ dropping in RDWAIT: read completes (dmaACK issued), then IDLE.
REQ-031 Hold counter (9 bits) counts GRANTED/RDWAIT cycles; at MAX_HOLD with no read pending -> YIELD: dmaGNT=0, cpuHOLD=0 for exactly 1 cycle, counter cleared, then WAITCPU if dmaREQ else IDLE.
REQ-032 dmaDIN SHALL hold last read value until next read completes.
REQ-033 memWE and memRE SHALL never be high in the same cycle.

Reset
REQ-034 reset=0: state IDLE; dmaGNT, dmaACK, cpuHOLD, memWE, memRE, dmaERR = 0; dmaDIN, memADDR, memDOUT = 0; hold counter 0.
REQ-035 clear=1 SHALL force the reset values at the next edge, including mid-read (read result discarded, no dmaACK).
REQ-036 Reset or clear mid-write SHALL not extend a memWE already issued; no further writes.

Verification
REQ-037 dmaREQ=1, cpuBUSY=0 -> cpuHOLD at cycle 1, dmaGNT at cycle 2; dmaWR addr 00100, data 5252 -> memWE=1, memADDR=00100, memDOUT=5252, dmaACK same cycle.
REQ-038 Granted, dmaRD addr 00100, model returns 5252 with MEM_LAT=2 -> dmaDIN=5252 and dmaACK exactly 2 cycles after memRE.
REQ-039 dmaREQ=1 with cpuBUSY=1 for 5 cycles -> dmaGNT stays 0 until 1 cycle after cpuBUSY falls.
REQ-040 256-word burst, MAX_HOLD=256 -> one-cycle dmaGNT=0/cpuHOLD=0 gap, then regrant; all 256 words correct in memory.
REQ-041 dmaRD+dmaWR together, and dmaWR with dmaGNT=0 -> no memWE/memRE, dmaERR=1 until reset or clear.
REQ-042 clear asserted during RDWAIT -> no dmaACK, dmaGNT=0, state IDLE next cycle; async reset low mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/dma_mem_responder_if.sv
// DMA / CPU / memory signal bundle for dma_mem_responder.
// The slave modport is the responder's view; the master modport is the disk/CPU/memory side.
interface dma_mem_responder_if;
    logic        dmaREQ;
    logic        dmaRD;
    logic        dmaWR;
    logic [14:0] dmaADDR;
    logic [11:0] dmaDOUT;
    logic        dmaGNT;
    logic [11:0] dmaDIN;
    logic        dmaACK;
    logic        cpuBUSY;
    logic        cpuHOLD;
    logic [14:0] memADDR;
    logic [11:0] memDOUT;
    logic [11:0] memDIN;
    logic        memWE;
    logic        memRE;
    logic        dmaERR;

    modport slave (
        input  dmaREQ, dmaRD, dmaWR, dmaADDR, dmaDOUT, cpuBUSY, memDIN,
        output dmaGNT, dmaDIN, dmaACK, cpuHOLD, memADDR, memDOUT, memWE, memRE, dmaERR
    );

    modport master (
        output dmaREQ, dmaRD, dmaWR, dmaADDR, dmaDOUT, cpuBUSY, memDIN,
        input  dmaGNT, dmaDIN, dmaACK, cpuHOLD, memADDR, memDOUT, memWE, memRE, dmaERR
    );
endinterface

// File: rtl/dma_mem_responder.sv
// Arbitrates memory between the CPU and a disk DMA engine, performs single-word DMA reads and
// writes, and forces a one-cycle CPU slot after MAX_HOLD consecutive granted cycles.
module dma_mem_responder #(
    parameter int unsigned MEM_LAT  = 2,
    parameter int unsigned MAX_HOLD = 256
) (
    input logic                  clk,
    input logic                  reset,
    input logic                  clear,
    dma_mem_responder_if.slave   bus
);
    typedef enum logic [2:0] {StIdle, StWaitCpu, StGranted, StRdWait, StYield} state_e;

    state_e      r_state;
    logic [8:0]  r_hold;
    logic [2:0]  r_lat;
    logic        r_gnt;
    logic        r_ack;
    logic        r_cpu_hold;
    logic        r_we;
    logic        r_re;
    logic        r_err;
    logic [11:0] r_din;
    logic [11:0] r_mdout;
    logic [14:0] r_maddr;

    logic w_both;
    logic w_bad;
    logic w_hold_done;
    logic w_lat_done;

    assign w_both      = bus.dmaRD & bus.dmaWR;
    // Any strobe is illegal without a grant, during a pending read, or when both fire together.
    assign w_bad       = (bus.dmaRD | bus.dmaWR) & (~r_gnt | (r_state == StRdWait) | w_both);
    assign w_hold_done = ({1'b0, r_hold} + 10'd1) >= 10'(MAX_HOLD);
    assign w_lat_done  = (r_lat == 3'(MEM_LAT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_hold     <= '0;
            r_lat      <= '0;
            r_gnt      <= 1'b0;
            r_ack      <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_err      <= 1'b0;
            r_din      <= '0;
            r_mdout    <= '0;
            r_maddr    <= '0;
        end else if (clear) begin
            r_state    <= StIdle;
            r_hold     <= '0;
            r_lat      <= '0;
            r_gnt      <= 1'b0;
            r_ack      <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_err      <= 1'b0;
            r_din      <= '0;
            r_mdout    <= '0;
            r_maddr    <= '0;
        end else begin
            r_we  <= 1'b0;
            r_re  <= 1'b0;
            r_ack <= 1'b0;
            if (w_bad) r_err <= 1'b1;

            case (r_state)
                StIdle: begin
                    if (bus.dmaREQ) begin
                        r_state    <= StWaitCpu;
                        r_cpu_hold <= 1'b1;
                    end
                end
                StWaitCpu: begin
                    if (!bus.dmaREQ) begin
                        r_state    <= StIdle;
                        r_cpu_hold <= 1'b0;
                    end else if (!bus.cpuBUSY) begin
                        r_state <= StGranted;
                        r_gnt   <= 1'b1;
                        r_hold  <= '0;
                    end
                end
                StGranted: begin
                    r_hold <= r_hold + 9'd1;
                    if (bus.dmaRD && !w_both) begin
                        r_re    <= 1'b1;
                        r_maddr <= bus.dmaADDR;
                        r_lat   <= 3'd1;
                        r_state <= StRdWait;
                    end else begin
                        if (bus.dmaWR && !w_both) begin
                            r_we    <= 1'b1;
                            r_ack   <= 1'b1;
                            r_maddr <= bus.dmaADDR;
                            r_mdout <= bus.dmaDOUT;
                        end
                        if (!bus.dmaREQ || w_hold_done) begin
                            r_state    <= bus.dmaREQ ? StYield : StIdle;
                            r_gnt      <= 1'b0;
                            r_cpu_hold <= 1'b0;
                            r_hold     <= '0;
                        end
                    end
                end
                StRdWait: begin
                    r_hold <= r_hold + 9'd1;
                    if (w_lat_done) begin
                        r_din <= bus.memDIN;
                        r_ack <= 1'b1;
                        if (!bus.dmaREQ || w_hold_done) begin
                            r_state    <= bus.dmaREQ ? StYield : StIdle;
                            r_gnt      <= 1'b0;
                            r_cpu_hold <= 1'b0;
                            r_hold     <= '0;
                        end else begin
                            r_state <= StGranted;
                        end
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                StYield: begin
                    r_hold <= '0;
                    if (bus.dmaREQ) begin
                        r_state    <= StWaitCpu;
                        r_cpu_hold <= 1'b1;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.dmaGNT  = r_gnt;
    assign bus.dmaDIN  = r_din;
    assign bus.dmaACK  = r_ack;
    assign bus.cpuHOLD = r_cpu_hold;
    assign bus.memADDR = r_maddr;
    assign bus.memDOUT = r_mdout;
    assign bus.memWE   = r_we;
    assign bus.memRE   = r_re;
    assign bus.dmaERR  = r_err;
endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed bench for dma_mem_responder with a latency-accurate memory model.
module tb_dma_mem_responder;
    localparam int MEM_LAT  = 2;
    localparam int MAX_HOLD = 256;

    logic clk;
    logic reset;
    logic clear;
    int   n_err;
    int   n_chk;

    dma_mem_responder_if bus ();

    dma_mem_responder #(
        .MEM_LAT  (MEM_LAT),
        .MAX_HOLD (MAX_HOLD)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: read data is only valid in the cycle before the DUT should capture it.
    logic [11:0] mem [0:32767];
    logic [7:0]  r_sh;
    logic [8:0]  w_rv;
    assign w_rv       = {r_sh, bus.memRE};
    assign bus.memDIN = w_rv[MEM_LAT-1] ? mem[bus.memADDR] : 12'hEEE;

    always @(posedge clk or negedge reset) begin
        if (!reset) r_sh <= '0;
        else        r_sh <= {r_sh[6:0], bus.memRE};
    end

    always @(posedge clk) begin
        if (bus.memWE) mem[bus.memADDR] <= bus.memDOUT;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int w;
        int gap;
        int both0;
        int acks;
        int first_gap;
        int bad;

        n_err = 0;
        n_chk = 0;
        reset = 1'b0;
        clear = 1'b0;
        bus.dmaREQ  = 1'b0;
        bus.dmaRD   = 1'b0;
        bus.dmaWR   = 1'b0;
        bus.dmaADDR = '0;
        bus.dmaDOUT = '0;
        bus.cpuBUSY = 1'b0;

        // Reset values
        #12;
        chk("rst_gnt", bus.dmaGNT, 0);
        chk("rst_hold", bus.cpuHOLD, 0);
        #10 reset = 1'b1;
        tick();
        chk("rst_ack", bus.dmaACK, 0);
        chk("rst_we_re", {bus.memWE, bus.memRE}, 0);
        chk("rst_err", bus.dmaERR, 0);
        chk("rst_din", bus.dmaDIN, 0);
        chk("rst_maddr", bus.memADDR, 0);
        chk("rst_mdout", bus.memDOUT, 0);

        // Request/grant timing, then one write
        bus.dmaREQ = 1'b1;
        tick();
        chk("req_c1_hold", bus.cpuHOLD, 1);
        chk("req_c1_gnt", bus.dmaGNT, 0);
        tick();
        chk("req_c2_gnt", bus.dmaGNT, 1);
        bus.dmaWR   = 1'b1;
        bus.dmaADDR = 15'o00100;
        bus.dmaDOUT = 12'o5252;
        tick();
        bus.dmaWR = 1'b0;
        chk("wr_we", bus.memWE, 1);
        chk("wr_re", bus.memRE, 0);
        chk("wr_addr", bus.memADDR, 15'o00100);
        chk("wr_data", bus.memDOUT, 12'o5252);
        chk("wr_ack", bus.dmaACK, 1);
        tick();
        chk("wr_pulse", {bus.memWE, bus.dmaACK}, 0);
        chk("wr_err", bus.dmaERR, 0);

        // Read with MEM_LAT=2; dmaREQ drops while the read is pending
        bus.dmaRD   = 1'b1;
        bus.dmaADDR = 15'o00100;
        tick();
        bus.dmaRD  = 1'b0;
        bus.dmaREQ = 1'b0;
        chk("rd_re", bus.memRE, 1);
        chk("rd_we", bus.memWE, 0);
        chk("rd_ack_c0", bus.dmaACK, 0);
        tick();
        chk("rd_ack_c1", bus.dmaACK, 0);
        tick();
        chk("rd_ack_c2", bus.dmaACK, 1);
        chk("rd_din", bus.dmaDIN, 12'o5252);
        chk("rd_drop_gnt", bus.dmaGNT, 0);
        chk("rd_drop_hold", bus.cpuHOLD, 0);
        tick();
        chk("rd_ack_pulse", bus.dmaACK, 0);
        chk("rd_din_held", bus.dmaDIN, 12'o5252);

        // CPU busy for 5 cycles delays the grant
        bus.dmaREQ  = 1'b1;
        bus.cpuBUSY = 1'b1;
        tick();
        chk("busy_hold", bus.cpuHOLD, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("busy_gnt", bus.dmaGNT, 0);
        end
        bus.cpuBUSY = 1'b0;
        tick();
        chk("busy_regnt", bus.dmaGNT, 1);

        // 256-word write burst across the MAX_HOLD boundary
        w = 0; gap = 0; both0 = 0; acks = 0; first_gap = -1;
        for (int c = 0; c < 262; c++) begin
            if (bus.dmaACK) acks++;
            if (bus.dmaGNT) begin
                if (w < 256) begin
                    bus.dmaWR   = 1'b1;
                    bus.dmaADDR = 15'(15'o1000 + w);
                    bus.dmaDOUT = 12'(w * 37 + 5);
                    w++;
                end else begin
                    bus.dmaWR = 1'b0;
                end
            end else begin
                bus.dmaWR = 1'b0;
                gap++;
                if (first_gap < 0) first_gap = c;
                if (!bus.cpuHOLD) both0++;
            end
            tick();
        end
        chk("burst_words", w, 256);
        chk("burst_acks", acks, 256);
        chk("burst_gap_at", first_gap, 256);
        chk("burst_both0", both0, 1);
        chk("burst_gnt0", gap, 2);
        chk("burst_regnt", bus.dmaGNT, 1);
        chk("burst_err", bus.dmaERR, 0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[15'(15'o1000 + i)] !== 12'(i * 37 + 5)) bad++;
        end
        chk("burst_mem", bad, 0);

        // Simultaneous strobes: no access, sticky error, stays granted
        bus.dmaRD = 1'b1;
        bus.dmaWR = 1'b1;
        tick();
        bus.dmaRD = 1'b0;
        bus.dmaWR = 1'b0;
        chk("both_we_re", {bus.memWE, bus.memRE}, 0);
        chk("both_ack", bus.dmaACK, 0);
        chk("both_err", bus.dmaERR, 1);
        chk("both_gnt", bus.dmaGNT, 1);
        bus.dmaREQ = 1'b0;
        tick();
        chk("drop_gnt", {bus.dmaGNT, bus.cpuHOLD}, 0);
        chk("err_sticky", bus.dmaERR, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_err", bus.dmaERR, 0);

        // Write without grant
        bus.dmaWR   = 1'b1;
        bus.dmaADDR = 15'o3000;
        tick();
        bus.dmaWR = 1'b0;
        chk("nognt_we", bus.memWE, 0);
        chk("nognt_err", bus.dmaERR, 1);
        tick();
        chk("nognt_sticky", bus.dmaERR, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;

        // Clear during a pending read
        bus.dmaREQ = 1'b1;
        tick();
        tick();
        chk("rdclr_gnt", bus.dmaGNT, 1);
        bus.dmaRD   = 1'b1;
        bus.dmaADDR = 15'o1005;
        tick();
        bus.dmaRD = 1'b0;
        chk("rdclr_re", bus.memRE, 1);
        clear      = 1'b1;
        bus.dmaREQ = 1'b0;
        tick();
        clear = 1'b0;
        chk("rdclr_ack", bus.dmaACK, 0);
        chk("rdclr_gnt0", bus.dmaGNT, 0);
        chk("rdclr_din", bus.dmaDIN, 0);
        tick();
        chk("rdclr_noack", bus.dmaACK, 0);

        // Asynchronous reset mid-write
        bus.dmaREQ = 1'b1;
        tick();
        tick();
        bus.dmaWR   = 1'b1;
        bus.dmaADDR = 15'o2000;
        bus.dmaDOUT = 12'o1234;
        tick();
        bus.dmaWR = 1'b0;
        chk("arst_pre_we", bus.memWE, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_gnt", bus.dmaGNT, 0);
        chk("arst_we", bus.memWE, 0);
        chk("arst_ack", bus.dmaACK, 0);
        chk("arst_hold", bus.cpuHOLD, 0);
        chk("arst_maddr", bus.memADDR, 0);
        #2 reset = 1'b1;
        bus.dmaREQ = 1'b0;
        tick();
        chk("arst_after", {bus.memWE, bus.dmaGNT}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
